// File: rtl/prbs9_checker.sv
// Self-synchronising PRBS9 (x^9 + x^5 + 1) checker: slices symbols to bits, locks a local LFSR
// to the stream, and counts checked bits and bit errors once locked.
module prbs9_checker #(
    parameter int NB_INPUT = 8,
    parameter int NB_CNT   = 32,
    parameter int WIN_LEN  = 32,
    parameter int LOCK_THR = 0,
    parameter int LOSS_THR = 4
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic signed [NB_INPUT-1:0] i_symb,
    input  logic                       i_clear,
    output logic                       o_lock,
    output logic                       o_err,
    output logic        [NB_CNT-1:0]   o_bit_count,
    output logic        [NB_CNT-1:0]   o_err_count
);

    // state     | meaning
    // ST_LOAD   | shift 9 received bits straight into the local LFSR
    // ST_ACQ    | free-run the LFSR for one window, lock if errors <= LOCK_THR
    // ST_LOCKED | count bits/errors, drop lock when a window reaches LOSS_THR errors
    typedef enum logic [1:0] {ST_LOAD, ST_ACQ, ST_LOCKED} state_t;

    localparam int NB_WIN = $clog2(WIN_LEN + 1);

    state_t              state_q, state_d;
    logic [8:0]          lfsr_q, lfsr_d;
    logic [3:0]          load_cnt_q, load_cnt_d;
    logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
    logic [NB_WIN-1:0]   win_err_q, win_err_d;
    logic                err_q, err_d;
    logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;

    logic                beat;
    logic                rx_bit;
    logic                pred;
    logic                mis;
    logic                win_last;
    logic [NB_WIN-1:0]   win_err_inc;
    logic                unused_symb_lsbs;

    assign beat             = i_enable & i_valid;
    assign rx_bit           = i_symb[NB_INPUT-1];
    assign pred             = lfsr_q[8] ^ lfsr_q[4];
    assign mis              = rx_bit ^ pred;
    assign win_last         = (win_cnt_q == NB_WIN'(WIN_LEN - 1));
    assign win_err_inc      = (mis && (win_err_q != NB_WIN'(WIN_LEN))) ? win_err_q + NB_WIN'(1) : win_err_q;
    assign unused_symb_lsbs = ^i_symb[NB_INPUT-2:0];

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        load_cnt_d = load_cnt_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        err_d      = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (beat) begin
            unique case (state_q)
                ST_LOAD: begin
                    lfsr_d     = {lfsr_q[7:0], rx_bit};
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd8) begin
                        state_d    = ST_ACQ;
                        load_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end
                end
                ST_ACQ: begin
                    lfsr_d    = {lfsr_q[7:0], pred};
                    win_cnt_d = win_cnt_q + NB_WIN'(1);
                    win_err_d = win_err_inc;
                    if (win_last) begin
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                        load_cnt_d = '0;
                        state_d    = (win_err_inc <= NB_WIN'(LOCK_THR)) ? ST_LOCKED : ST_LOAD;
                    end
                end
                ST_LOCKED: begin
                    lfsr_d    = {lfsr_q[7:0], pred};
                    err_d     = mis;
                    win_cnt_d = win_cnt_q + NB_WIN'(1);
                    win_err_d = win_err_inc;
                    if (bit_cnt_q != '1)
                        bit_cnt_d = bit_cnt_q + NB_CNT'(1);
                    if (mis && (err_cnt_q != '1))
                        err_cnt_d = err_cnt_q + NB_CNT'(1);
                    // Loss is checked first so a loss on the window's last beat still drops lock.
                    if (win_err_inc >= NB_WIN'(LOSS_THR)) begin
                        state_d    = ST_LOAD;
                        load_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end else if (win_last) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                default: state_d = ST_LOAD;
            endcase

            if (i_clear) begin
                bit_cnt_d = '0;
                err_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state_q    <= ST_LOAD;
            lfsr_q     <= '0;
            load_cnt_q <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            err_q      <= 1'b0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            load_cnt_q <= load_cnt_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
            err_q      <= err_d;
            bit_cnt_q  <= bit_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_lock      = (state_q == ST_LOCKED);
    assign o_err       = err_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// Bench for prbs9_checker: a 32-bit-counter instance and a 4-bit-counter instance share one
// stimulus stream and are compared every cycle against a queue-based reference model.
module tb_prbs9_checker;

    localparam int WIN      = 32;
    localparam int LOCK_THR = 0;
    localparam int LOSS_THR = 4;
    localparam int PH_LOAD   = 0;
    localparam int PH_ACQ    = 1;
    localparam int PH_LOCKED = 2;
    localparam longint CAP_MAIN = 64'hFFFF_FFFF;
    localparam longint CAP_SAT  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, en, vld, clr;
    logic signed [7:0] symb;
    logic              lock, err, lock_s, err_s;
    logic [31:0]       bcnt, ecnt;
    logic [3:0]        bcnt_s, ecnt_s;

    prbs9_checker dut (
        .clk(clk), .i_rst(rst_n), .i_enable(en), .i_valid(vld), .i_symb(symb), .i_clear(clr),
        .o_lock(lock), .o_err(err), .o_bit_count(bcnt), .o_err_count(ecnt)
    );

    prbs9_checker #(.NB_CNT(4)) dut_sat (
        .clk(clk), .i_rst(rst_n), .i_enable(en), .i_valid(vld), .i_symb(symb), .i_clear(clr),
        .o_lock(lock_s), .o_err(err_s), .o_bit_count(bcnt_s), .o_err_count(ecnt_s)
    );

    int vectors = 0;
    int miscompares = 0;

    // Transmit stream: x[n] = x[n-9] ^ x[n-5], oldest bit at index 0.
    bit tx_hist[$];
    // Reference model: local sequence history (oldest first), phase, window bookkeeping.
    bit     loc[$];
    int     ph, m_n, m_werr;
    bit     m_err;
    longint m_bits, m_errs, m_bits_s, m_errs_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tx_next(output bit b);
        b = tx_hist[0] ^ tx_hist[4];
        tx_hist.push_back(b);
        void'(tx_hist.pop_front());
    endtask

    task automatic loc_push(input bit b);
        loc.push_back(b);
        void'(loc.pop_front());
    endtask

    function automatic longint sat_inc(input longint v, input longint cap);
        return (v < cap) ? v + 1 : v;
    endfunction

    task automatic model(input bit rst_v, input bit beat, input bit rx, input bit clr_v);
        bit pred, mis;
        if (!rst_v) begin
            ph = PH_LOAD; m_n = 0; m_werr = 0; m_err = 0;
            m_bits = 0; m_errs = 0; m_bits_s = 0; m_errs_s = 0;
            loc.delete();
            repeat (9) loc.push_back(1'b0);
            return;
        end
        m_err = 0;
        if (!beat) return;
        pred = loc[0] ^ loc[4];
        mis  = (rx != pred);
        case (ph)
            PH_LOAD: begin
                loc_push(rx);
                m_n++;
                if (m_n == 9) begin ph = PH_ACQ; m_n = 0; m_werr = 0; end
            end
            PH_ACQ: begin
                loc_push(pred);
                m_n++;
                if (mis && m_werr < WIN) m_werr++;
                if (m_n == WIN) begin
                    ph = (m_werr <= LOCK_THR) ? PH_LOCKED : PH_LOAD;
                    m_n = 0; m_werr = 0;
                end
            end
            default: begin
                loc_push(pred);
                m_err    = mis;
                m_bits   = sat_inc(m_bits, CAP_MAIN);
                m_bits_s = sat_inc(m_bits_s, CAP_SAT);
                if (mis) begin
                    m_errs   = sat_inc(m_errs, CAP_MAIN);
                    m_errs_s = sat_inc(m_errs_s, CAP_SAT);
                    m_werr++;
                end
                m_n++;
                if (m_werr >= LOSS_THR) begin
                    ph = PH_LOAD; m_n = 0; m_werr = 0;
                end else if (m_n == WIN) begin
                    m_n = 0; m_werr = 0;
                end
            end
        endcase
        if (clr_v) begin
            m_bits = 0; m_errs = 0; m_bits_s = 0; m_errs_s = 0;
        end
    endtask

    task automatic step(input bit rst_v, input bit en_v, input bit vld_v, input bit clr_v, input bit flip);
        bit beat, rx, txb;
        logic signed [7:0] s;
        beat = rst_v && en_v && vld_v;
        rx   = 1'b0;
        if (beat) begin
            tx_next(txb);
            rx = txb ^ flip;
        end
        s = 8'($urandom_range(0, 127));
        if (rx) s = ~s;
        if (!beat && ($urandom_range(0, 1) == 1)) s = ~s;
        rst_n = rst_v; en = en_v; vld = vld_v; clr = clr_v; symb = s;
        @(posedge clk);
        #1;
        model(rst_v, beat, rx, clr_v);
        vectors++;
        chk("lock",       64'(lock),   64'(ph == PH_LOCKED));
        chk("err",        64'(err),    64'(m_err));
        chk("bit_count",  64'(bcnt),   64'(m_bits));
        chk("err_count",  64'(ecnt),   64'(m_errs));
        chk("lock_sat",   64'(lock_s), 64'(ph == PH_LOCKED));
        chk("err_sat",    64'(err_s),  64'(m_err));
        chk("bit_count4", 64'(bcnt_s), 64'(m_bits_s));
        chk("err_count4", 64'(ecnt_s), 64'(m_errs_s));
    endtask

    initial begin
        bit [8:0] seed;
        int first_lock, pulses, beats, cyc;
        bit lock40, lock41, lock3;
        seed = 9'b110101010;
        for (int i = 8; i >= 0; i--) tx_hist.push_back(seed[i]);
        repeat (9) loc.push_back(1'b0);
        ph = PH_LOAD; m_n = 0; m_werr = 0; m_err = 0;
        m_bits = 0; m_errs = 0; m_bits_s = 0; m_errs_s = 0;
        rst_n = 1'b0; en = 1'b0; vld = 1'b0; clr = 1'b0; symb = '0;

        // Reset
        repeat (3) step(0, 1, 1, 0, 0);
        chk("reset_lock", 64'(lock), 64'd0);
        chk("reset_bcnt", 64'(bcnt), 64'd0);

        // Clean lock on beat 41
        first_lock = 0;
        for (int i = 1; i <= 41; i++) begin
            step(1, 1, 1, 0, 0);
            if (lock && first_lock == 0) first_lock = i;
        end
        chk("first_lock_beat", 64'(first_lock), 64'd41);
        repeat (100) step(1, 1, 1, 0, 0);
        chk("bcnt_100", 64'(bcnt), 64'd100);
        chk("ecnt_clean", 64'(ecnt), 64'd0);
        chk("bcnt4_sat", 64'(bcnt_s), 64'd15);

        // Single error, then clean to the window boundary
        step(1, 1, 1, 0, 1);
        chk("single_err_pulse", 64'(err), 64'd1);
        chk("single_ecnt", 64'(ecnt), 64'd1);
        chk("single_lock", 64'(lock), 64'd1);
        pulses = 0;
        for (int i = 0; i < 27; i++) begin
            step(1, 1, 1, 0, 0);
            if (err) pulses++;
        end
        chk("single_followup_errs", 64'(pulses), 64'd0);

        // Clear on a beat
        step(1, 1, 1, 1, 0);
        chk("clear_bcnt", 64'(bcnt), 64'd0);
        chk("clear_ecnt", 64'(ecnt), 64'd0);
        chk("clear_lock", 64'(lock), 64'd1);

        // Loss of lock after 4 inverted symbols
        repeat (3) step(1, 1, 1, 0, 1);
        lock3 = lock;
        step(1, 1, 1, 0, 1);
        chk("loss_lock_before", 64'(lock3), 64'd1);
        chk("loss_lock_after", 64'(lock), 64'd0);
        chk("loss_ecnt", 64'(ecnt), 64'd4);

        // Re-lock, counters resume from 4
        repeat (40) step(1, 1, 1, 0, 0);
        lock40 = lock;
        step(1, 1, 1, 0, 0);
        chk("relock_40", 64'(lock40), 64'd0);
        chk("relock_41", 64'(lock), 64'd1);
        chk("relock_bcnt_held", 64'(bcnt), 64'd4);
        repeat (5) step(1, 1, 1, 0, 0);
        chk("resume_bcnt", 64'(bcnt), 64'd9);
        chk("resume_ecnt", 64'(ecnt), 64'd4);

        // Reset mid-lock
        step(0, 1, 1, 0, 0);
        chk("midreset_lock", 64'(lock), 64'd0);
        chk("midreset_bcnt", 64'(bcnt), 64'd0);
        chk("midreset_ecnt", 64'(ecnt), 64'd0);

        // Gapped strobe / toggled enable
        beats = 0; cyc = 0; lock40 = 1'b1; lock41 = 1'b0;
        while (beats < 41 && cyc < 1000) begin
            bit e, v;
            v = (cyc % 3 == 0);
            e = ($urandom_range(0, 3) != 0);
            step(1, e, v, 0, 0);
            if (e && v) begin
                beats++;
                if (beats == 40) lock40 = lock;
                if (beats == 41) lock41 = lock;
            end
            cyc++;
        end
        chk("gap_beats", 64'(beats), 64'd41);
        chk("gap_lock_40", 64'(lock40), 64'd0);
        chk("gap_lock_41", 64'(lock41), 64'd1);

        // Persistent error every 10th bit: 4-bit counters saturate, o_err keeps pulsing
        pulses = 0;
        for (int i = 1; i <= 90; i++) begin
            step(1, 1, 1, 0, (i % 10 == 0));
            if (err_s) pulses++;
        end
        chk("sat_pulses", 64'(pulses), 64'd9);
        chk("sat_bcnt4", 64'(bcnt_s), 64'd15);
        chk("sat_ecnt4", 64'(ecnt_s), 64'd9);
        chk("sat_bcnt", 64'(bcnt), 64'd90);
        chk("sat_lock", 64'(lock), 64'd1);

        // Random mix of gaps, errors, clears and occasional resets
        for (int i = 0; i < 1500; i++) begin
            bit r, e, v, c, f;
            r = ($urandom_range(0, 399) != 0);
            e = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 24) == 0);
            step(r, e, v, c, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
